// File: rtl/bp_me_buffer_array.sv
// ---------------------------------------------------------------------------
// bp_me_buffer_array
//
// Array of independent message buffers placed between the LCE/memory
// networks and the CCE core, one channel per message class. Each channel
// is a circular buffer with a ready&valid producer side and a valid->yumi
// consumer side. It also reports occupancy and a high-water flag, supports
// a per-channel flush, and holds a sticky underflow error flag.
//
// Parameters
//   channels_p    number of independent channels (>= 1)
//   width_p       message width in bits, same for every channel
//   els_p         entries per channel (power of two, >= 2)
//   hwm_p         high-water threshold (1 <= hwm_p <= els_p)
//   cnt_width_lp  occupancy counter width, $clog2(els_p+1)
//
// Ports (channel c of any packed bus is at [c*W +: W])
//   clk_i         clock; all state updates on the rising edge
//   reset_n_i     synchronous, active-low reset
//   v_i           producer valid, per channel
//   data_i        producer data, channels_p*width_p
//   ready_o       channel can accept a message this cycle
//   v_o           head entry valid
//   data_o        head entry data, same packing as data_i
//   yumi_i        consumer dequeues the head this cycle
//   flush_i       discard all entries of the channel
//   count_o       per-channel occupancy, channels_p*cnt_width_lp
//   high_water_o  occupancy >= hwm_p
//   err_o         sticky underflow error (yumi with no valid head)
//
// Optional feature: define BP_ME_BUFFER_ARRAY_BYPASS_EN to let a message
// arriving at an empty channel appear on v_o/data_o in the same cycle.
// This creates a combinational path from v_i/data_i to v_o/data_o. When the
// macro is undefined, the minimum latency is one cycle and there is no
// input-to-output combinational path.
// ---------------------------------------------------------------------------
module bp_me_buffer_array #(
   parameter  int channels_p   = 4,
   parameter  int width_p      = 64,
   parameter  int els_p        = 8,
   parameter  int hwm_p        = 6,
   localparam int cnt_width_lp = $clog2(els_p + 1)
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,

   input  logic [channels_p-1:0]              v_i,
   input  logic [channels_p*width_p-1:0]      data_i,
   output logic [channels_p-1:0]              ready_o,

   output logic [channels_p-1:0]              v_o,
   output logic [channels_p*width_p-1:0]      data_o,
   input  logic [channels_p-1:0]              yumi_i,

   input  logic [channels_p-1:0]              flush_i,
   output logic [channels_p*cnt_width_lp-1:0] count_o,
   output logic [channels_p-1:0]              high_water_o,
   output logic [channels_p-1:0]              err_o
);

   localparam int ptr_width_lp = $clog2(els_p);

   genvar gi;
   generate
      for (gi = 0; gi < channels_p; gi++) begin : g_ch
         logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
         logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
         logic [cnt_width_lp-1:0] count_reg, count_next;
         logic                    err_reg, err_next;
         logic [width_p-1:0]      mem_reg [els_p];

         logic               full, empty;
         logic               enq, deq;
         logic               ready, valid;
         logic [width_p-1:0] in_data, head_data;

         assign in_data   = data_i[gi*width_p +: width_p];
         assign head_data = mem_reg[rptr_reg];

         assign full  = (count_reg == cnt_width_lp'(els_p));
         assign empty = (count_reg == '0);

         // Flush blanks both handshakes, which is what gives it priority
         // over any enqueue or dequeue requested in the same cycle.
         assign ready = reset_n_i & ~full & ~flush_i[gi];

`ifdef BP_ME_BUFFER_ARRAY_BYPASS_EN
         // An empty channel presents the incoming message directly.
         assign valid = (~empty | v_i[gi]) & ~flush_i[gi];
         assign data_o[gi*width_p +: width_p] = empty ? in_data : head_data;

         // A bypassed message consumed in the same cycle is never stored.
         // A bypassed message not consumed is stored as an ordinary enqueue.
         assign enq = v_i[gi] & ready & ~(empty & yumi_i[gi]);

         // Only a stored head can be dequeued from the array; the
         // bypass case is covered by suppressing the enqueue above.
         assign deq = yumi_i[gi] & valid & ~empty;
`else
         assign valid = ~empty & ~flush_i[gi];
         assign data_o[gi*width_p +: width_p] = head_data;
         assign enq   = v_i[gi] & ready;
         assign deq   = yumi_i[gi] & valid;
`endif

         assign ready_o[gi] = ready;
         assign v_o[gi]     = valid;

         // Next-state for pointers, occupancy and error flag.
         always_comb begin
            rptr_next  = rptr_reg;
            wptr_next  = wptr_reg;
            count_next = count_reg;
            err_next   = err_reg;

            if (flush_i[gi]) begin
               rptr_next  = '0;
               wptr_next  = '0;
               count_next = '0;
            end else begin
               if (enq) begin
                  wptr_next = wptr_reg + ptr_width_lp'(1);
               end
               if (deq) begin
                  rptr_next = rptr_reg + ptr_width_lp'(1);
               end
               if (enq && !deq) begin
                  count_next = count_reg + cnt_width_lp'(1);
               end else if (!enq && deq) begin
                  count_next = count_reg - cnt_width_lp'(1);
               end
            end

            // Illegal dequeue: flagged, but otherwise ignored.
            if (yumi_i[gi] && !valid) begin
               err_next = 1'b1;
            end
         end

         always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
               rptr_reg  <= '0;
               wptr_reg  <= '0;
               count_reg <= '0;
               err_reg   <= 1'b0;
            end else begin
               rptr_reg  <= rptr_next;
               wptr_reg  <= wptr_next;
               count_reg <= count_next;
               err_reg   <= err_next;
            end
         end

         // Storage holds no reset: an entry is only observable once its
         // slot has been written after the pointers were cleared.
         always_ff @(posedge clk_i) begin
            if (enq) begin
               mem_reg[wptr_reg] <= in_data;
            end
         end

         assign count_o[gi*cnt_width_lp +: cnt_width_lp] = count_reg;
         assign high_water_o[gi] = (count_reg >= cnt_width_lp'(hwm_p));
         assign err_o[gi]        = err_reg;
      end
   endgenerate

endmodule

// File: tb/tb_bp_me_buffer_array.sv
// ---------------------------------------------------------------------------
// tb_bp_me_buffer_array
//
// Self-checking bench for bp_me_buffer_array. It uses the default
// parameters. A reference model keeps one queue of messages per channel plus
// a sticky error bit. Expected outputs are derived from queue sizes and
// queue heads. Directed scenarios run first, followed by a randomized run
// that includes occasional flushes and mid-operation resets.
// ---------------------------------------------------------------------------
module tb_bp_me_buffer_array;

   localparam int CH   = 4;
   localparam int W    = 64;
   localparam int ELS  = 8;
   localparam int HWM  = 6;
   localparam int CW   = $clog2(ELS + 1);

`ifdef BP_ME_BUFFER_ARRAY_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk;
   logic              reset_n;
   logic [CH-1:0]     v_i, ready_o, v_o, yumi_i, flush_i, high_water_o, err_o;
   logic [CH*W-1:0]   data_i, data_o;
   logic [CH*CW-1:0]  count_o;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model state
   logic [W-1:0] q [CH][$];
   bit           err_m [CH];

   bp_me_buffer_array dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .v_i          (v_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .v_o          (v_o),
      .data_o       (data_o),
      .yumi_i       (yumi_i),
      .flush_i      (flush_i),
      .count_o      (count_o),
      .high_water_o (high_water_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- model ----------------
   function automatic bit m_ready(int c);
      return reset_n && (q[c].size() < ELS) && !flush_i[c];
   endfunction

   function automatic bit m_valid(int c);
      if (flush_i[c]) return 1'b0;
      return (q[c].size() > 0) || (BYP && v_i[c]);
   endfunction

   function automatic logic [W-1:0] m_data(int c);
      if (q[c].size() > 0) return q[c][0];
      return data_i[c*W +: W];
   endfunction

   function automatic int m_count(int c);
      return q[c].size();
   endfunction

   // Advance the model by one clock using the inputs present before the edge.
   task automatic tick();
      bit vo [CH];
      bit rd [CH];
      @(posedge clk);
      for (int c = 0; c < CH; c++) begin
         vo[c] = m_valid(c);
         rd[c] = m_ready(c);
      end
      for (int c = 0; c < CH; c++) begin
         if (!reset_n) begin
            q[c].delete();
            err_m[c] = 1'b0;
         end else begin
            if (yumi_i[c] && !vo[c]) err_m[c] = 1'b1;
            if (flush_i[c]) begin
               q[c].delete();
            end else if (BYP && q[c].size() == 0 && v_i[c] && yumi_i[c]) begin
               // passes straight through, nothing stored
            end else begin
               if (yumi_i[c] && vo[c]) void'(q[c].pop_front());
               if (v_i[c] && rd[c]) q[c].push_back(data_i[c*W +: W]);
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      v_i = '0; yumi_i = '0; flush_i = '0; data_i = '0;
   endtask

   task automatic set_data(int c, logic [W-1:0] val);
      data_i[c*W +: W] = val;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (ready_o !== '0) begin
         n_miss++;
         $display("FAIL reset_ready_during got %b exp %b", ready_o, 4'b0);
      end
      tick();
      tick();
      n_vec++;
      if (ready_o !== '0) begin
         n_miss++;
         $display("FAIL reset_ready_held got %b exp %b", ready_o, 4'b0);
      end
      n_vec++;
      if (v_o !== '0 || count_o !== '0 || high_water_o !== '0 || err_o !== '0) begin
         n_miss++;
         $display("FAIL reset_state got v=%b cnt=%h hw=%b err=%b exp all zero",
                  v_o, count_o, high_water_o, err_o);
      end
      reset_n = 1'b1;
      #1;
      n_vec++;
      if (ready_o !== 4'hF) begin
         n_miss++;
         $display("FAIL reset_release_ready got %b exp %b", ready_o, 4'hF);
      end
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= ELS; i++) begin
         v_i[0] = 1'b1;
         set_data(0, W'(i));
         #1;
         n_vec++;
         if (ready_o[0] !== 1'b1) begin
            n_miss++;
            $display("FAIL fill_ready i=%0d got %b exp 1", i, ready_o[0]);
         end
         n_vec++;
         if (high_water_o[0] !== (m_count(0) >= HWM)) begin
            n_miss++;
            $display("FAIL fill_hw i=%0d got %b exp %b", i, high_water_o[0], m_count(0) >= HWM);
         end
         tick();
      end
      idle_inputs();
      #1;
      n_vec++;
      if (ready_o[0] !== 1'b0 || count_o[0 +: CW] !== CW'(ELS) || high_water_o[0] !== 1'b1) begin
         n_miss++;
         $display("FAIL full_state got rdy=%b cnt=%0d hw=%b exp rdy=0 cnt=8 hw=1",
                  ready_o[0], count_o[0 +: CW], high_water_o[0]);
      end
      for (int i = 1; i <= ELS; i++) begin
         yumi_i[0] = 1'b1;
         #1;
         n_vec++;
         if (v_o[0] !== 1'b1 || data_o[0 +: W] !== W'(i)) begin
            n_miss++;
            $display("FAIL drain_order i=%0d got v=%b d=%h exp v=1 d=%h", i, v_o[0], data_o[0 +: W], W'(i));
         end
         tick();
      end
      idle_inputs();
      #1;
      n_vec++;
      if (v_o[0] !== 1'b0 || count_o[0 +: CW] !== '0 || high_water_o[0] !== 1'b0) begin
         n_miss++;
         $display("FAIL drained_state got v=%b cnt=%0d hw=%b exp 0 0 0",
                  v_o[0], count_o[0 +: CW], high_water_o[0]);
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < ELS; i++) begin
         v_i[1] = 1'b1;
         set_data(1, {$urandom, $urandom});
         tick();
      end
      // Full: producer and consumer together -> dequeue only
      v_i[1] = 1'b1; yumi_i[1] = 1'b1;
      set_data(1, {$urandom, $urandom});
      #1;
      n_vec++;
      if (ready_o[1] !== 1'b0 || v_o[1] !== 1'b1 || data_o[W +: W] !== q[1][0]) begin
         n_miss++;
         $display("FAIL full_simul got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h",
                  ready_o[1], v_o[1], data_o[W +: W], q[1][0]);
      end
      tick();
      // Steady enq+deq across pointer wrap
      for (int i = 0; i < 12; i++) begin
         v_i[1] = 1'b1; yumi_i[1] = 1'b1;
         set_data(1, {$urandom, $urandom});
         #1;
         n_vec++;
         if (count_o[CW +: CW] !== CW'(7) || data_o[W +: W] !== m_data(1)) begin
            n_miss++;
            $display("FAIL steady_wrap i=%0d got cnt=%0d d=%h exp cnt=7 d=%h",
                     i, count_o[CW +: CW], data_o[W +: W], m_data(1));
         end
         tick();
      end
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         yumi_i[1] = 1'b1;
         #1;
         n_vec++;
         if (v_o[1] !== 1'b1 || data_o[W +: W] !== m_data(1)) begin
            n_miss++;
            $display("FAIL wrap_drain i=%0d got v=%b d=%h exp v=1 d=%h",
                     i, v_o[1], data_o[W +: W], m_data(1));
         end
         tick();
      end
      idle_inputs();
      #1;
      n_vec++;
      if (count_o[CW +: CW] !== '0) begin
         n_miss++;
         $display("FAIL wrap_empty got cnt=%0d exp 0", count_o[CW +: CW]);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         v_i[2] = 1'b1; set_data(2, {$urandom, $urandom});
         v_i[0] = (i < 2); set_data(0, {$urandom, $urandom});
         v_i[1] = (i == 0); set_data(1, {$urandom, $urandom});
         tick();
      end
      idle_inputs();
      flush_i[2] = 1'b1; v_i[2] = 1'b1; yumi_i[2] = 1'b1;
      set_data(2, {$urandom, $urandom});
      #1;
      n_vec++;
      if (ready_o[2] !== 1'b0 || v_o[2] !== 1'b0) begin
         n_miss++;
         $display("FAIL flush_blocks got rdy=%b v=%b exp 0 0", ready_o[2], v_o[2]);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (err_o[2] !== 1'b1 || count_o[2*CW +: CW] !== '0) begin
         n_miss++;
         $display("FAIL flush_after got err=%b cnt=%0d exp err=1 cnt=0",
                  err_o[2], count_o[2*CW +: CW]);
      end
      for (int c = 0; c < CH; c++) begin
         if (c == 2) continue;
         n_vec++;
         if (count_o[c*CW +: CW] !== CW'(m_count(c)) || err_o[c] !== err_m[c]
             || (m_count(c) > 0 && data_o[c*W +: W] !== m_data(c))) begin
            n_miss++;
            $display("FAIL flush_isolation ch%0d got cnt=%0d err=%b d=%h exp cnt=%0d err=%b d=%h",
                     c, count_o[c*CW +: CW], err_o[c], data_o[c*W +: W],
                     m_count(c), err_m[c], m_data(c));
         end
      end
      // Drain remaining entries without error
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < CH; c++) yumi_i[c] = (m_count(c) > 0);
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_underflow();
      yumi_i[3] = 1'b1;
      #1;
      n_vec++;
      if (v_o[3] !== 1'b0) begin
         n_miss++;
         $display("FAIL underflow_v got %b exp 0", v_o[3]);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (err_o[3] !== 1'b1 || count_o[3*CW +: CW] !== '0) begin
         n_miss++;
         $display("FAIL underflow_err got err=%b cnt=%0d exp 1 0", err_o[3], count_o[3*CW +: CW]);
      end
      tick(); tick(); tick();
      n_vec++;
      if (err_o[3] !== 1'b1) begin
         n_miss++;
         $display("FAIL underflow_sticky got %b exp 1", err_o[3]);
      end
   endtask

   task automatic test_bypass();
      v_i[0] = 1'b1; yumi_i[0] = 1'b1;
      set_data(0, 64'hAB);
      #1;
      n_vec++;
      if (v_o[0] !== BYP || (BYP && data_o[0 +: W] !== 64'hAB)) begin
         n_miss++;
         $display("FAIL bypass_same got v=%b d=%h exp v=%b d=%h", v_o[0], data_o[0 +: W], BYP, 64'hAB);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (count_o[0 +: CW] !== (BYP ? CW'(0) : CW'(1)) || v_o[0] !== !BYP
          || (!BYP && data_o[0 +: W] !== 64'hAB)) begin
         n_miss++;
         $display("FAIL bypass_next got cnt=%0d v=%b d=%h exp cnt=%0d v=%b d=%h",
                  count_o[0 +: CW], v_o[0], data_o[0 +: W], BYP ? 0 : 1, !BYP, 64'hAB);
      end
      if (!BYP) begin
         yumi_i[0] = 1'b1;
         tick();
         idle_inputs();
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 3; i++) begin
         v_i = '1;
         for (int c = 0; c < CH; c++) set_data(c, {$urandom, $urandom});
         tick();
      end
      reset_n = 1'b0;
      v_i = '1; yumi_i = 4'b0101;
      tick();
      reset_n = 1'b1;
      idle_inputs();
      #1;
      for (int c = 0; c < CH; c++) begin
         n_vec++;
         if (count_o[c*CW +: CW] !== '0 || v_o[c] !== 1'b0 || err_o[c] !== 1'b0
             || high_water_o[c] !== 1'b0 || ready_o[c] !== 1'b1) begin
            n_miss++;
            $display("FAIL midop_reset ch%0d got cnt=%0d v=%b err=%b hw=%b rdy=%b exp 0 0 0 0 1",
                     c, count_o[c*CW +: CW], v_o[c], err_o[c], high_water_o[c], ready_o[c]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         reset_n = ($urandom_range(0, 399) != 0);
         for (int c = 0; c < CH; c++) begin
            v_i[c]     = ($urandom_range(0, 9) < 6);
            yumi_i[c]  = ($urandom_range(0, 9) < 5);
            flush_i[c] = ($urandom_range(0, 99) < 3);
            set_data(c, {$urandom, $urandom});
         end
         #1;
         for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (ready_o[c] !== m_ready(c) || v_o[c] !== m_valid(c)
                || count_o[c*CW +: CW] !== CW'(m_count(c))
                || high_water_o[c] !== (m_count(c) >= HWM) || err_o[c] !== err_m[c]
                || (m_valid(c) && data_o[c*W +: W] !== m_data(c))) begin
               n_miss++;
               $display("FAIL random n=%0d ch%0d got rdy=%b v=%b cnt=%0d hw=%b err=%b d=%h exp rdy=%b v=%b cnt=%0d hw=%b err=%b d=%h",
                        n, c, ready_o[c], v_o[c], count_o[c*CW +: CW], high_water_o[c], err_o[c],
                        data_o[c*W +: W], m_ready(c), m_valid(c), m_count(c),
                        m_count(c) >= HWM, err_m[c], m_data(c));
            end
         end
         tick();
      end
      reset_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      for (int c = 0; c < CH; c++) err_m[c] = 1'b0;
      test_reset();
      test_fill_drain();
      test_full_simul();
      test_flush();
      test_underflow();
      test_bypass();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
